ddr3_rd_assembler: RTL and testbench

- Read-return stage between the DDR3 DQ/DQS capture flops and the read-data async FIFO (f1 write side), in the ck domain.
- Turns per-cycle rise/fall DQ byte pairs of each BL8 read burst into 32-bit words and pushes them to the FIFO.
- Tracks outstanding reads issued by ctrl_operation, detects missing or truncated bursts by timeout, and buffers words against FIFO backpressure.

---
 rtl/ddr3_rd_pkg.sv | 25 ++
 rtl/rd_word_buf.sv | 57 +++++
 rtl/ddr3_rd_assembler.sv | 183 ++++++++++++++++++
 tb/tb_ddr3_rd_assembler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rd_pkg.sv
// ddr3_rd_pkg: shared DDR3 read-path types and constants.
// Used by the read assembler and its word buffer.
package ddr3_rd_pkg;

  localparam int DDR3_DQ_BITS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COLLECT = 2'd2
  } rd_asm_state_e;

  function automatic int beats_f(input int bl);
    return bl / 2;
  endfunction

  function automatic int words_f(input int bl, input int dq);
    return (bl * dq) / 32;
  endfunction

  function automatic int cbits_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rd_word_buf.sv
// rd_word_buf: small synchronous word FIFO in the ck domain.
// Writes when full and reads when empty are ignored.
module rd_word_buf
  import ddr3_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = cbits_f(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          w_en;
  logic          r_en;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign w_en  = wr && !full;
  assign r_en  = rd && !empty;
  assign rdata = mem[rp];

  // storage array, no reset needed
  always_ff @(posedge ck) begin
    if (w_en) mem[wp] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (w_en) wp <= wp + AW'(1);
      if (r_en) rp <= rp + AW'(1);
      case ({w_en, r_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_rd_assembler.sv
// ddr3_rd_assembler: packs BL8 DQ beats into words for the read FIFO.
// Optional RD_ASSEMBLER_STATS_EN adds burst/error counters.
module ddr3_rd_assembler
  import ddr3_rd_pkg::*;
#(
  parameter int DQ_BITS   = DDR3_DQ_BITS,
  parameter int BL        = 8,
  parameter int WORD_W    = 32,
  parameter int MAX_OUT   = 4,
  parameter int TIMEOUT   = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic                         rd_start,
  input  logic                         beat_valid,
  input  logic [DQ_BITS-1:0]           dq_rise,
  input  logic [DQ_BITS-1:0]           dq_fall,
  input  logic                         fifo_full,
  output logic [WORD_W-1:0]            word_data,
  output logic                         word_push,
  output logic                         rd_done,
  output logic                         rd_err,
  output logic                         overflow,
  output logic [$clog2(MAX_OUT+1)-1:0] pending
`ifdef RD_ASSEMBLER_STATS_EN
  ,
  output logic [15:0]                  stat_bursts,
  output logic [7:0]                   stat_errs
`endif
);

  localparam int BEATS = beats_f(BL);
  localparam int PW    = $clog2(MAX_OUT+1);
  localparam int TW    = cbits_f(TIMEOUT);
  localparam int BW    = cbits_f(BEATS);
  localparam int HW    = 2 * DQ_BITS;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT-1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS-1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_OUT);

  rd_asm_state_e state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [HW-1:0] lo_q, lo_n;
  logic [PW-1:0] pend_n;

  logic fin;
  logic last;
  logic wr_word;
  logic acc;
  logic rej;
  logic drop;

  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] bdata;
  logic              bfull;
  logic              bempty;
  logic              brd;

  assign wdata = {dq_fall, dq_rise, lo_q};
  assign drop  = wr_word && bfull;
  assign brd   = !bempty && !fifo_full;

  rd_word_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (WORD_W)
  ) u_buf (
    .ck    (ck),
    .rst_n (rst_n),
    .wr    (wr_word),
    .rd    (brd),
    .wdata (wdata),
    .rdata (bdata),
    .full  (bfull),
    .empty (bempty)
  );

  // next state, beat packing, timeouts and pending count
  always_comb begin
    state_n = state;
    tmo_n   = tmo;
    bcnt_n  = bcnt;
    lo_n    = lo_q;
    fin     = 1'b0;
    last    = 1'b0;
    rd_err  = 1'b0;
    wr_word = 1'b0;
    pend_n  = pending;
    unique case (state)
      IDLE: begin
        tmo_n  = '0;
        bcnt_n = '0;
        if (pending != '0) state_n = WAIT;
      end
      WAIT: begin
        if (beat_valid) begin
          lo_n    = {dq_fall, dq_rise};
          bcnt_n  = BW'(1);
          tmo_n   = '0;
          state_n = COLLECT;
        end else if (tmo == TMO_LAST) begin
          rd_err = 1'b1;
          fin    = 1'b1;
          tmo_n  = '0;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      COLLECT: begin
        if (beat_valid) begin
          tmo_n  = '0;
          bcnt_n = bcnt + BW'(1);
          if (bcnt[0]) wr_word = 1'b1;
          else         lo_n = {dq_fall, dq_rise};
          if (bcnt == BEAT_LAST) begin
            last   = 1'b1;
            fin    = 1'b1;
            bcnt_n = '0;
          end
        end else if (tmo == TMO_LAST) begin
          rd_err = 1'b1;
          fin    = 1'b1;
          tmo_n  = '0;
          bcnt_n = '0;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    acc = rd_start && ((pending != PEND_MAX) || fin);
    rej = rd_start && !acc;
    case ({acc, fin})
      2'b10:   pend_n = pending + PW'(1);
      2'b01:   pend_n = pending - PW'(1);
      default: pend_n = pending;
    endcase
    if (fin) state_n = (pend_n != '0) ? WAIT : IDLE;
  end

  // state, counters and registered outputs
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo       <= '0;
      bcnt      <= '0;
      lo_q      <= '0;
      pending   <= '0;
      rd_done   <= 1'b0;
      overflow  <= 1'b0;
      word_push <= 1'b0;
      word_data <= '0;
    end else begin
      state     <= state_n;
      tmo       <= tmo_n;
      bcnt      <= bcnt_n;
      lo_q      <= lo_n;
      pending   <= pend_n;
      rd_done   <= last;
      overflow  <= overflow | drop | rej;
      word_push <= brd;
      if (brd) word_data <= bdata;
    end
  end

`ifdef RD_ASSEMBLER_STATS_EN
  // saturating burst and error counters
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts <= '0;
      stat_errs   <= '0;
    end else begin
      if (rd_done && (stat_bursts != '1))
        stat_bursts <= stat_bursts + 16'd1;
      if (rd_err && (stat_errs != '1))
        stat_errs <= stat_errs + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_rd_assembler.sv
// tb_ddr3_rd_assembler: directed bench with a word scoreboard.
// Expected words are queued at stimulus time and popped on word_push.
module tb_ddr3_rd_assembler;

  localparam int TIMEOUT = 16;

  logic        ck;
  logic        rst_n;
  logic        rd_start;
  logic        beat_valid;
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;
  logic        fifo_full;
  logic [31:0] word_data;
  logic        word_push;
  logic        rd_done;
  logic        rd_err;
  logic        overflow;
  logic [2:0]  pending;
`ifdef RD_ASSEMBLER_STATS_EN
  logic [15:0] stat_bursts;
  logic [7:0]  stat_errs;
`endif

  ddr3_rd_assembler #(
    .DQ_BITS   (8),
    .BL        (8),
    .WORD_W    (32),
    .MAX_OUT   (4),
    .TIMEOUT   (TIMEOUT),
    .BUF_DEPTH (4)
  ) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .rd_start   (rd_start),
    .beat_valid (beat_valid),
    .dq_rise    (dq_rise),
    .dq_fall    (dq_fall),
    .fifo_full  (fifo_full),
    .word_data  (word_data),
    .word_push  (word_push),
    .rd_done    (rd_done),
    .rd_err     (rd_err),
    .overflow   (overflow),
    .pending    (pending)
`ifdef RD_ASSEMBLER_STATS_EN
    ,
    .stat_bursts (stat_bursts),
    .stat_errs   (stat_errs)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int last_push_cyc = 0;
  logic [31:0] sb_q[$];

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge ck) begin
    if (rst_n) begin
      if (word_push) begin
        push_cnt++;
        last_push_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL push_unexpected got %0h want none", word_data);
        end else begin
          chk("word", word_data, sb_q.pop_front());
        end
      end
      if (rd_done) done_cnt++;
      if (rd_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic start_n(input int n);
    rd_start = 1'b1;
    repeat (n) step();
    rd_start = 1'b0;
  endtask

  task automatic burst(input logic [63:0] d, input int nb, input bit exp);
    if (exp)
      for (int k = 0; k < nb / 2; k++) sb_q.push_back(d[32*k +: 32]);
    for (int j = 0; j < nb; j++) begin
      beat_valid = 1'b1;
      dq_rise    = d[16*j +: 8];
      dq_fall    = d[16*j+8 +: 8];
      step();
    end
    beat_valid = 1'b0;
    dq_rise    = '0;
    dq_fall    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b0, s0, p0, d0, e0;
    rst_n      = 1'b0;
    rd_start   = 1'b0;
    beat_valid = 1'b0;
    dq_rise    = '0;
    dq_fall    = '0;
    fifo_full  = 1'b0;
    idle(3);
    chk("rst_pending", pending, 0);
    chk("rst_push", word_push, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", word_data, 0);
    rst_n = 1'b1;
    idle(2);

    // single read
    start_n(1);
    idle(2);
    b0 = cyc;
    burst(64'h8877665544332211, 4, 1);
    idle(6);
    chk("t1_pushes", push_cnt, 2);
    chk("t1_done", done_cnt, 1);
    chk("t1_pending", pending, 0);
    chk("t1_latency", last_push_cyc, b0 + 5);
    chk("t1_ovf", overflow, 0);

    // missing burst
    p0 = push_cnt;
    e0 = err_cnt;
    s0 = cyc;
    start_n(1);
    idle(TIMEOUT + 4);
    chk("t3_err", err_cnt, e0 + 1);
    chk("t3_err_time", err_cyc - (s0 + 1), TIMEOUT);
    chk("t3_pending", pending, 0);
    chk("t3_pushes", push_cnt, p0);

    // back-to-back reads
    p0 = push_cnt;
    d0 = done_cnt;
    start_n(4);
    chk("t2_peak", pending, 4);
    chk("t2_ovf_pre", overflow, 0);
    start_n(1);
    chk("t2_pend_hold", pending, 4);
    chk("t2_ovf", overflow, 1);
    burst(64'h0807060504030201, 4, 1);
    burst(64'h1817161514131211, 4, 1);
    burst(64'h2827262524232221, 4, 1);
    burst(64'h3837363534333231, 4, 1);
    idle(8);
    chk("t2_done", done_cnt, d0 + 4);
    chk("t2_pending", pending, 0);
    chk("t2_pushes", push_cnt, p0 + 8);

    // truncated burst then a clean one
    p0 = push_cnt;
    e0 = err_cnt;
    d0 = done_cnt;
    start_n(1);
    idle(2);
    b0 = cyc;
    burst(64'h0000C6C5C4C3C2C1, 3, 1);
    idle(TIMEOUT + 4);
    chk("t4_err", err_cnt, e0 + 1);
    chk("t4_err_time", err_cyc, b0 + 3 + TIMEOUT - 1);
    chk("t4_pushes", push_cnt, p0 + 1);
    chk("t4_pending", pending, 0);
    chk("t4_no_done", done_cnt, d0);
    start_n(1);
    idle(2);
    burst(64'hD8D7D6D5D4D3D2D1, 4, 1);
    idle(6);
    chk("t4_next_done", done_cnt, d0 + 1);
    chk("t4_next_pushes", push_cnt, p0 + 3);

    // backpressure
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    p0 = push_cnt;
    fifo_full = 1'b1;
    start_n(3);
    idle(1);
    burst(64'hA8A7A6A5A4A3A2A1, 4, 1);
    burst(64'hB8B7B6B5B4B3B2B1, 4, 1);
    idle(1);
    chk("t5_ovf_early", overflow, 0);
    burst(64'hE8E7E6E5E4E3E2E1, 4, 0);
    idle(3);
    chk("t5_ovf", overflow, 1);
    chk("t5_held", push_cnt, p0);
    chk("t5_pending", pending, 0);
    fifo_full = 1'b0;
    idle(8);
    chk("t5_pushes", push_cnt, p0 + 4);

    // reset mid-burst
    d0 = done_cnt;
    start_n(1);
    idle(2);
    burst(64'h000000000000F2F1, 2, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_pending", pending, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_push", word_push, 0);
    chk("t6_done", rd_done, 0);
    chk("t6_err", rd_err, 0);
    chk("t6_data", word_data, 0);
    step();
    rst_n = 1'b1;
    step();
    p0 = push_cnt;
    start_n(1);
    idle(2);
    burst(64'h7877767574737271, 4, 1);
    idle(6);
    chk("t6_next_done", done_cnt, d0 + 1);
    chk("t6_next_pushes", push_cnt, p0 + 2);
    chk("t6_next_pending", pending, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
